// File: rtl/inst_mem_loader_pkg.sv
// Shared data-path definitions for the instruction-memory loader:
// word geometry and the loader FSM encoding.
package inst_mem_loader_pkg;
  localparam int WORD_BYTES = 4;
  localparam int IDX_W      = $clog2(WORD_BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } ld_state_t;
endpackage

// File: rtl/inst_mem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The slave side is the loader; the master side is stream source plus memory.
interface inst_mem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/inst_mem_loader_byte_packer.sv
// Big-endian byte-to-word assembler: lane idx 0 lands in the top byte.
// word_full flags the byte that completes the word.
module byte_packer
  import inst_mem_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [IDX_W-1:0]      idx,
  input  logic [7:0]            din,
  output logic [8*WORD_BYTES-1:0] word,
  output logic                  word_full
);
  assign word_full = en && (idx == IDX_W'(WORD_BYTES-1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word <= '0;
    end else begin
      for (int i = 0; i < WORD_BYTES; i++)
        if (en && idx == IDX_W'(i)) word[8*(WORD_BYTES-1-i) +: 8] <= din;
    end
  end
endmodule

// File: rtl/inst_mem_loader.sv
// Streams bytes into 32-bit words and writes them to instruction memory
// starting at BASE_ADDR; oversize requests are rejected with a sticky error.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'd0,
  parameter int          DEPTH_WORDS = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [15:0]        num_words,
  inst_mem_loader_if.slave   bus,
  output logic               busy,
  output logic               done,
  output logic               error
);
  localparam logic [16:0] DEPTH_LIM = 17'(DEPTH_WORDS);

  ld_state_t        state, nxt;
  logic [15:0]      cnt;
  logic [31:0]      addr;
  logic [IDX_W-1:0] byte_idx;
  logic             accept, word_full, too_big, zero_len;

  assign accept   = bus.in_valid && (state == RECV);
  assign too_big  = {1'b0, num_words} > DEPTH_LIM;
  assign zero_len = (num_words == 16'd0);
  assign bus.mem_addr = addr;

  byte_packer u_pack (
    .clk       (clk),
    .reset     (reset),
    .en        (accept),
    .idx       (byte_idx),
    .din       (bus.in_data),
    .word      (bus.mem_wdata),
    .word_full (word_full)
  );

  always_comb begin
    nxt          = state;
    bus.in_ready = 1'b0;
    bus.mem_we   = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: if (start) begin
        if (zero_len)      nxt = DONE;
        else if (!too_big) nxt = RECV;
      end
      RECV: begin
        bus.in_ready = 1'b1;
        busy         = 1'b1;
        if (word_full) nxt = WRITE;
      end
      WRITE: begin
        bus.mem_we = 1'b1;
        busy       = 1'b1;
        nxt        = (cnt == 16'd1) ? DONE : RECV;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      addr     <= BASE_ADDR;
      byte_idx <= '0;
      error    <= 1'b0;
    end else begin
      // a zero-length start is still an accepted start, so it clears error
      if (state == IDLE && start) begin
        if (zero_len) begin
          error <= 1'b0;
        end else if (too_big) begin
          error <= 1'b1;
        end else begin
          error    <= 1'b0;
          cnt      <= num_words;
          addr     <= BASE_ADDR;
          byte_idx <= '0;
        end
      end
      if (accept) byte_idx <= byte_idx + 1'b1;
      if (state == WRITE) begin
        addr <= addr + 32'd4;
        cnt  <= cnt - 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomized and directed bench for inst_mem_loader with a word-level scoreboard.
module tb_inst_mem_loader;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'd0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_words = '0;
  logic        busy, done, error;

  inst_mem_loader_if bus();

  inst_mem_loader #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_words (num_words),
    .bus       (bus.slave),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic [31:0] imem [0:DEPTH-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // memory-side model: every write must match the next expected (addr, data)
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_we", 32'(bus.mem_we), 32'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("we_addr", bus.mem_addr, e[63:32]);
        chk("we_data", bus.mem_wdata, e[31:0]);
        imem[bus.mem_addr[7:2]] = bus.mem_wdata;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [15:0] n);
    num_words = n;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit chk_rdy);
    int k;
    bus.in_valid = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      if (chk_rdy) chk("stall_ready", 32'(bus.in_ready), 32'd1);
      tick();
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    k = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && k < 20) begin
      k++;
      @(negedge clk);
    end
    if (bus.in_ready !== 1'b1) chk("ready_timeout", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    @(negedge clk);
    while (done !== 1'b1 && k < 20) begin
      k++;
      @(negedge clk);
    end
    chk("done_seen", 32'(done), 32'd1);
    tick();
    @(negedge clk);
    chk("idle_after_done", {30'd0, busy, done}, 32'd0);
    tick();
  endtask

  function automatic logic [31:0] word_of(input logic [7:0] bs[$], input int w);
    return {bs[4*w], bs[4*w+1], bs[4*w+2], bs[4*w+3]};
  endfunction

  task automatic run_load(input logic [7:0] bs[$], input int max_gap, input int stall_at);
    int n;
    n = bs.size() / 4;
    for (int w = 0; w < n; w++) exp_q.push_back({BASE + 32'(4*w), word_of(bs, w)});
    pulse_start(16'(n));
    for (int i = 0; i < bs.size(); i++)
      send_byte(bs[i], (i == stall_at) ? 3 : int'($urandom_range(max_gap, 0)), i == stall_at);
    wait_done();
    chk("q_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic rand_bytes(input int n, output logic [7:0] bs[$]);
    bs = {};
    for (int i = 0; i < 4*n; i++) bs.push_back(8'($urandom));
  endtask

  logic [7:0]  prog[$];
  logic [31:0] prog_w[6];
  logic [7:0]  bs[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    prog = '{8'h00,8'hA6,8'h08,8'h20, 8'h21,8'h42,8'h00,8'h02, 8'h21,8'h83,8'h00,8'h01,
             8'h00,8'h8A,8'h20,8'h20, 8'h02,8'h85,8'h28,8'h22, 8'h03,8'h08,8'h30,8'h23};
    prog_w = '{32'h00A60820, 32'h21420002, 32'h21830001, 32'h008A2020, 32'h02852822, 32'h03083023};

    // reset state
    #12;
    chk("rst_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_we",    32'(bus.mem_we), 32'd0);
    chk("rst_addr",  bus.mem_addr, BASE);
    chk("rst_wdata", bus.mem_wdata, 32'd0);
    chk("rst_flags", {29'd0, busy, done, error}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) tick();
    chk("idle_after_rst", {30'd0, busy, bus.in_ready}, 32'd0);

    // reference program, then readback through the memory model
    run_load(prog, 0, -1);
    for (int w = 0; w < 6; w++) chk("readback", imem[w], prog_w[w]);

    // same program with a 3-cycle stall before the third byte
    run_load(prog, 0, 2);

    // zero-length load
    pulse_start(16'd0);
    chk("zero_done", {30'd0, busy, done}, 32'd3);
    tick();
    chk("zero_after", {30'd0, busy, done}, 32'd0);
    tick();

    // oversize load is rejected, then a valid start clears error
    pulse_start(16'(DEPTH + 1));
    chk("over_err", {30'd0, error, busy}, 32'd2);
    repeat (2) tick();
    chk("over_idle", {29'd0, error, busy, bus.in_ready}, 32'd4);
    rand_bytes(1, bs);
    run_load(bs, 1, -1);
    chk("err_cleared", 32'(error), 32'd0);

    // reset in the middle of word 3
    rand_bytes(4, bs);
    for (int w = 0; w < 2; w++) exp_q.push_back({BASE + 32'(4*w), word_of(bs, w)});
    pulse_start(16'd4);
    for (int i = 0; i < 10; i++) send_byte(bs[i], 0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    chk("mid_rst_we",    32'(bus.mem_we), 32'd0);
    chk("mid_rst_addr",  bus.mem_addr, BASE);
    chk("mid_rst_wdata", bus.mem_wdata, 32'd0);
    chk("mid_rst_flags", {29'd0, busy, done, error}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (4) tick();
    chk("mid_rst_q", 32'(exp_q.size()), 32'd0);
    chk("mid_rst_idle", 32'(busy), 32'd0);
    rand_bytes(2, bs);
    run_load(bs, 1, -1);

    // start pulsed during RECV is ignored
    rand_bytes(2, bs);
    for (int w = 0; w < 2; w++) exp_q.push_back({BASE + 32'(4*w), word_of(bs, w)});
    pulse_start(16'd2);
    for (int i = 0; i < 5; i++) send_byte(bs[i], 0, 1'b0);
    pulse_start(16'd1);
    chk("start_ignored_busy", 32'(busy), 32'd1);
    chk("start_ignored_addr", bus.mem_addr, BASE + 32'd4);
    for (int i = 5; i < 8; i++) send_byte(bs[i], 0, 1'b0);
    wait_done();
    chk("start_ignored_q", 32'(exp_q.size()), 32'd0);

    // random loads with random byte gaps
    for (int t = 0; t < 6; t++) begin
      rand_bytes(int'($urandom_range(8, 1)), bs);
      run_load(bs, 2, -1);
    end

    // full-capacity load reaches the last word address
    rand_bytes(DEPTH, bs);
    run_load(bs, 0, -1);
    chk("full_last_word", imem[DEPTH-1], word_of(bs, DEPTH-1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/inst_mem_loader.md
INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'd0: byte address of the first word written.
REQ-002 SHALL have parameter DEPTH_WORDS, default 64: instruction memory capacity in 32-bit words.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: one-cycle pulse that begins a load.
REQ-006 SHALL have port num_words, input, 16: word count, sampled on start.
REQ-007 SHALL have port in_valid, input, 1: byte-stream valid.
REQ-008 SHALL have port in_data, input, 8: stream byte.
REQ-009 SHALL have port in_ready, output, 1: loader accepts a byte this cycle.
REQ-010 SHALL have port mem_we, output, 1: instruction memory write enable.
REQ-011 SHALL have port mem_addr, output, 32: instruction memory byte address, word aligned.
REQ-012 SHALL have port mem_wdata, output, 32: instruction word to write.
REQ-013 SHALL have port busy, output, 1: load in progress.
REQ-014 SHALL have port done, output, 1: one-cycle pulse when a load completes.
REQ-015 SHALL have port error, output, 1: sticky flag for a rejected oversize load.

Function
REQ-016 SHALL implement FSM states IDLE, RECV, WRITE, DONE.
REQ-017 IDLE: start=1 with 0 < num_words <= DEPTH_WORDS SHALL latch the count, clear the byte index, set mem_addr=BASE_ADDR, and enter RECV.
REQ-018 IDLE: start=1 with num_words=0 SHALL go directly to DONE; no write occurs.
REQ-019 IDLE: start=1 with num_words > DEPTH_WORDS SHALL set error=1, stay in IDLE, and write nothing.
REQ-020 A later accepted start SHALL clear error.
REQ-021 in_ready SHALL be 1 only in RECV.
REQ-022 A byte SHALL be accepted on any edge where in_valid && in_ready.
REQ-023 in_valid low SHALL stall RECV indefinitely, with no timeout.
REQ-024 Bytes SHALL assemble big-endian: the first byte accepted goes to mem_wdata[31:24], the fourth to [7:0].
REQ-025 On the edge that accepts the 4th byte, the FSM SHALL enter WRITE.
REQ-026 mem_we SHALL be 1 for exactly the one cycle spent in WRITE, with mem_addr and mem_wdata stable.
REQ-027 On leaving WRITE, mem_addr SHALL increment by 4 and the remaining count SHALL decrement.
REQ-028 On leaving WRITE, the FSM SHALL go to RECV if words remain, otherwise to DONE.
REQ-029 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-030 busy SHALL be 1 in RECV, WRITE and DONE.
REQ-031 start while busy SHALL be ignored.
REQ-032 Bytes presented outside RECV SHALL be ignored; in_ready=0 makes them not consumed.
REQ-033 mem_addr arithmetic SHALL be 32-bit modulo; by REQ-019 it cannot exceed BASE_ADDR + 4*(DEPTH_WORDS-1).

Reset
REQ-034 reset=0 SHALL asynchronously force IDLE with in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, busy=0, done=0, error=0, count=0, byte index=0.
REQ-035 Reset mid-load SHALL abandon the partial word with no write; words already written are not undone.
REQ-036 After reset release, the block SHALL remain idle until the next start.

Structure
REQ-037 The FSM state encoding and the WORD_BYTES=4 constant SHALL live in the shared data-path package.
REQ-038 Byte assembly SHALL be a sub-module byte_packer: 8-bit in, 32-bit out, 2-bit index, word_full strobe.
REQ-039 No memory array SHALL exist in this block; it drives the existing instruction memory write port.

Verification
REQ-040 start, num_words=6, stream 00 A6 08 20 21 42 00 02 21 83 00 01 00 8A 20 20 02 85 28 22 03 08 30 23 -> six mem_we pulses at addr 0,4,...,20 with data 00A60820, 21420002, 21830001, 008A2020, 02852822, 03083023; then done pulse; readback through the instruction memory matches.
REQ-041 Same stream with in_valid low for 3 cycles between bytes 2 and 3 -> identical writes, in_ready held 1, no extra mem_we.
REQ-042 start, num_words=0 -> done the next cycle, mem_we never asserted, busy high for one cycle.
REQ-043 start, num_words=65 with DEPTH_WORDS=64 -> error=1, busy=0, no write; then start, num_words=1 -> error clears.
REQ-044 reset=0 after 2 bytes of word 3 -> all outputs at reset values immediately; no write at addr 8; a new load restarts at BASE_ADDR.
REQ-045 start pulsed during RECV -> ignored; count and address unaffected.
